// File: rtl/ip1_test_pkg.sv
// ---------------------------------------------------------------------------
// ip1_test_pkg
// Shared definitions for the ip1 config scan-chain test blocks.
//   state_t_sm_test2_rx : state encoding of the test2 receive state machine
//   CNT_W_DEF           : default width of bit index / error counters
//   SKIP_BITS_DEF       : default number of samples discarded before compare
//                         (ASIC chain latency)
// ---------------------------------------------------------------------------
package ip1_test_pkg;

    localparam int CNT_W_DEF     = 14;
    localparam int SKIP_BITS_DEF = 24;

    typedef enum logic [1:0] {
        IDLE_RX    = 2'd0,
        SKIP_RX    = 2'd1,
        COMPARE_RX = 2'd2,
        DONE_RX    = 2'd3
    } state_t_sm_test2_rx;

endpackage

// File: rtl/ip1_test2_rx_if.sv
// ---------------------------------------------------------------------------
// ip1_test2_rx_if
// Handshake/status bundle between the test2 sequencer side (master) and the
// test2 receive checker (slave).
//   master drives : rx_start_re, rx_bit_cnt_max, rx_i_expected_bit0
//   slave drives  : rx_o_expected_shift, rx_o_sample_bit, rx_o_sample_valid,
//                   rx_o_err_cnt, rx_o_first_err_idx, rx_o_status_done,
//                   rx_o_status_err, rx_state
// ---------------------------------------------------------------------------
interface ip1_test2_rx_if
    import ip1_test_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             rx_start_re;
    logic [CNT_W-1:0] rx_bit_cnt_max;
    logic             rx_i_expected_bit0;
    logic             rx_o_expected_shift;
    logic             rx_o_sample_bit;
    logic             rx_o_sample_valid;
    logic [CNT_W-1:0] rx_o_err_cnt;
    logic [CNT_W-1:0] rx_o_first_err_idx;
    logic             rx_o_status_done;
    logic             rx_o_status_err;
    logic [1:0]       rx_state;

    modport master (
        output rx_start_re, rx_bit_cnt_max, rx_i_expected_bit0,
        input  rx_o_expected_shift, rx_o_sample_bit, rx_o_sample_valid,
               rx_o_err_cnt, rx_o_first_err_idx, rx_o_status_done,
               rx_o_status_err, rx_state
    );

    modport slave (
        input  rx_start_re, rx_bit_cnt_max, rx_i_expected_bit0,
        output rx_o_expected_shift, rx_o_sample_bit, rx_o_sample_valid,
               rx_o_err_cnt, rx_o_first_err_idx, rx_o_status_done,
               rx_o_status_err, rx_state
    );
endinterface

// File: rtl/ip1_bit_sync.sv
// ---------------------------------------------------------------------------
// ip1_bit_sync
// Brings the ASIC config_out bit into the clk domain.
// Build option: IP1_TEST2_RX_SYNC_EN
//   defined   : 2-flop synchronizer (config_out truly asynchronous)
//   undefined : single input register (config_out already clk-registered)
// Ports:
//   clk  in  : clock
//   rst  in  : synchronous active-high reset (clears the fill tracker only)
//   d    in  : raw input bit
//   q    out : registered/synchronized bit
//   vld  out : high once the register chain holds post-reset data
// ---------------------------------------------------------------------------
module ip1_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic vld
);

`ifdef IP1_TEST2_RX_SYNC_EN
    localparam int DEPTH = 2;

    logic meta;
    logic stab;

    always_ff @(posedge clk) begin
        meta <= d;
        stab <= meta;
    end
`else
    localparam int DEPTH = 1;

    logic stab;

    always_ff @(posedge clk) begin
        stab <= d;
    end
`endif

    assign q = stab;

    // One marker bit per stage walks through after reset; the last stage
    // marks when q carries data captured after reset was released.
    logic [DEPTH-1:0] fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else begin
            fill <= (fill << 1) | DEPTH'(1);
        end
    end

    assign vld = fill[DEPTH-1];

endmodule

// File: rtl/ip1_test2_rx.sv
// ---------------------------------------------------------------------------
// ip1_test2_rx
// Receive end of the config scan-chain shift test. Samples config_out once
// per config clock period, discards the first SKIP_BITS samples (chain
// latency), then compares each sample with the expected-pattern bit,
// counting mismatches and recording the first mismatching compare index.
// Build option: IP1_TEST2_RX_SYNC_EN selects a 2-flop input synchronizer
// (otherwise one input register; sample_phase absorbs the 1-clk difference).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enable             : block select, low acts as reset
//   clk_counter_fc     : fast config clock phase counter
//   sample_phase       : phase value at which config_out is sampled
//   config_out         : ASIC serial output
//   rx (slave modport) : start/expected-bit inputs, sample/status outputs
// ---------------------------------------------------------------------------
module ip1_test2_rx
    import ip1_test_pkg::*;
#(
    parameter int SKIP_BITS = SKIP_BITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [6:0]    clk_counter_fc,
    input  logic [6:0]    sample_phase,
    input  logic          config_out,
    ip1_test2_rx_if.slave rx
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE_RX);
    localparam logic [1:0] ST_SKIP    = 2'(SKIP_RX);
    localparam logic [1:0] ST_COMPARE = 2'(COMPARE_RX);
    localparam logic [1:0] ST_DONE    = 2'(DONE_RX);

    localparam logic [CNT_W-1:0] ALL_ONES  = '1;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);
    localparam bit               SKIP_NONE = (SKIP_BITS == 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ALL_ONES) ? v : v + ONE;
    endfunction

    logic rst_int;
    assign rst_int = reset | ~enable;

    logic cfg_sync;
    logic cfg_vld;

    ip1_bit_sync u_sync (
        .clk (clk),
        .rst (rst_int),
        .d   (config_out),
        .q   (cfg_sync),
        .vld (cfg_vld)
    );

    logic [1:0]       state;
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic             status_done;
    logic             status_err;
    logic             expected_shift;
    logic             sample_bit;
    logic             sample_valid;

    logic sample_pt;
    logic mismatch;
    logic last_bit;
    logic no_bits;

    assign sample_pt = cfg_vld && (clk_counter_fc == sample_phase);
    assign mismatch  = cfg_sync ^ rx.rx_i_expected_bit0;
    assign no_bits   = (rx.rx_bit_cnt_max == '0);
    assign last_bit  = (bit_idx == rx.rx_bit_cnt_max - ONE);

    always_ff @(posedge clk) begin
        if (rst_int) begin
            state          <= ST_IDLE;
            skip_cnt       <= '0;
            bit_idx        <= '0;
            err_cnt        <= '0;
            first_err_idx  <= ALL_ONES;
            status_done    <= 1'b0;
            status_err     <= 1'b0;
            expected_shift <= 1'b0;
            sample_bit     <= 1'b0;
            sample_valid   <= 1'b0;
        end else begin
            expected_shift <= 1'b0;
            sample_valid   <= 1'b0;

            // sample_bit tracks every sample point so the phase can be
            // trimmed while the block idles.
            if (sample_pt) begin
                sample_bit <= cfg_sync;
            end

            case (state)
                ST_IDLE: begin
                    if (rx.rx_start_re) begin
                        state         <= ST_SKIP;
                        skip_cnt      <= '0;
                        bit_idx       <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= ALL_ONES;
                        status_done   <= 1'b0;
                        status_err    <= 1'b0;
                    end
                end

                ST_SKIP: begin
                    if (SKIP_NONE) begin
                        state <= ST_COMPARE;
                    end else if (sample_pt) begin
                        sample_valid <= 1'b1;
                        skip_cnt     <= skip_cnt + ONE;
                        if (skip_cnt == SKIP_LAST) begin
                            state <= ST_COMPARE;
                        end
                    end
                end

                ST_COMPARE: begin
                    if (sample_pt) begin
                        if (no_bits) begin
                            state <= ST_DONE;
                        end else begin
                            sample_valid   <= 1'b1;
                            expected_shift <= 1'b1;
                            bit_idx        <= bit_idx + ONE;
                            if (mismatch) begin
                                err_cnt    <= sat_inc(err_cnt);
                                status_err <= 1'b1;
                                if (err_cnt == '0) begin
                                    first_err_idx <= bit_idx;
                                end
                            end
                            if (last_bit) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    status_done <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx.rx_o_expected_shift = expected_shift;
    assign rx.rx_o_sample_bit     = sample_bit;
    assign rx.rx_o_sample_valid   = sample_valid;
    assign rx.rx_o_err_cnt        = err_cnt;
    assign rx.rx_o_first_err_idx  = first_err_idx;
    assign rx.rx_o_status_done    = status_done;
    assign rx.rx_o_status_err     = status_err;
    assign rx.rx_state            = state;

endmodule
